core_mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the core's instruction-fetch port and
//  its data load/store port. Arbitrates round-robin, sequences each access through a

---
 rtl/core_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_core_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency single-port memory between
// the instruction-fetch port and the data load/store port, and stalls the core while an access is in flight.
module core_mem_arbiter #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifetch_req_i,
  input  logic [ADDR_WIDTH-1:0] ifetch_addr_i,
  output logic [DATA_WIDTH-1:0] ifetch_rdata_o,
  output logic                  ifetch_valid_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_valid_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_e                state_q, state_d;
  logic                  last_data_q, last_data_d;
  logic                  gnt_data_q, gnt_data_d;
  logic                  store_q, store_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  dm_valid_q, dm_valid_d;
  logic                  pick_data;
  logic                  capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_data_q <= 1'b1;
      gnt_data_q  <= 1'b0;
      store_q     <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      store_q     <= store_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
    end
  end

  // On a tie the port that did not win last time gets the memory.
  assign pick_data = dmem_req_i & (~ifetch_req_i | ~last_data_q);

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    store_d     = store_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ifetch_req_i || dmem_req_i) begin
          mem_en_d    = 1'b1;
          mem_we_d    = pick_data & dmem_we_i;
          mem_addr_d  = pick_data ? dmem_addr_i : ifetch_addr_i;
          mem_wdata_d = dmem_wdata_i;
          last_data_d = pick_data;
          gnt_data_d  = pick_data;
          store_d     = pick_data & dmem_we_i;
          cnt_d       = LAT;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        // A zero-latency memory answers in the strobe cycle itself.
        if (cnt_q == 3'd0) capture = 1'b1;
        else begin
          cnt_d   = cnt_q - 3'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) capture = 1'b1;
        else cnt_d = cnt_q - 3'd1;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      state_d = S_RESP;
      if (gnt_data_q) begin
        dm_valid_d = 1'b1;
        if (!store_q) dm_rdata_d = mem_rdata_i;
      end else begin
        if_valid_d = 1'b1;
        if_rdata_d = mem_rdata_i;
      end
    end
  end

  assign ifetch_rdata_o = if_rdata_q;
  assign ifetch_valid_o = if_valid_q;
  assign dmem_rdata_o   = dm_rdata_q;
  assign dmem_valid_o   = dm_valid_q;
  assign mem_en_o       = mem_en_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign stall_o        = (ifetch_req_i & ~if_valid_q) | (dmem_req_i & ~dm_valid_q);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: three instances with memory latency 0, 1 and 3
// share a clock and a behavioural memory whose contents are a fixed function of address.
module tb_core_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req   [3];
  logic [9:0]  if_addr  [3];
  logic [31:0] if_rdata [3];
  logic        if_valid [3];
  logic        dm_req   [3];
  logic        dm_we    [3];
  logic [9:0]  dm_addr  [3];
  logic [31:0] dm_wdata [3];
  logic [31:0] dm_rdata [3];
  logic        dm_valid [3];
  logic        mem_en   [3];
  logic        mem_we   [3];
  logic [9:0]  mem_addr [3];
  logic [31:0] mem_wdata[3];
  logic [31:0] mem_rdata[3];
  logic        stall    [3];

  int errors = 0;
  int checks = 0;

  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  int          wr_cnt  = 0;

  function automatic logic [31:0] mem_fn(input logic [9:0] a);
    return (a == 10'h004) ? 32'h0050_0093 : {16'hA5C3, 6'd0, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    localparam int IDX = (LAT == 0) ? 0 : LAT - 1;
    logic [31:0] rd0;
    logic [31:0] pipe [8];

    assign rd0 = mem_en[g] ? mem_fn(mem_addr[g]) : 32'hBAD0_BAD0;
    always_ff @(posedge clk) begin
      pipe[0] <= rd0;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = (LAT == 0) ? rd0 : pipe[IDX];

    core_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .ifetch_req_i   (if_req[g]),
      .ifetch_addr_i  (if_addr[g]),
      .ifetch_rdata_o (if_rdata[g]),
      .ifetch_valid_o (if_valid[g]),
      .dmem_req_i     (dm_req[g]),
      .dmem_we_i      (dm_we[g]),
      .dmem_addr_i    (dm_addr[g]),
      .dmem_wdata_i   (dm_wdata[g]),
      .dmem_rdata_o   (dm_rdata[g]),
      .dmem_valid_o   (dm_valid[g]),
      .mem_en_o       (mem_en[g]),
      .mem_we_o       (mem_we[g]),
      .mem_addr_o     (mem_addr[g]),
      .mem_wdata_o    (mem_wdata[g]),
      .mem_rdata_i    (mem_rdata[g]),
      .stall_o        (stall[g])
    );
  end

  always @(posedge clk) begin
    if (mem_en[1] && mem_we[1]) begin
      wr_addr <= mem_addr[1];
      wr_data <= mem_wdata[1];
      wr_cnt  <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_once(input int g, input logic [9:0] a, input int exp_lat);
    int n;
    if_req[g]  = 1'b1;
    if_addr[g] = a;
    #1;
    chk($sformatf("d%0d stall at T", g), stall[g], 1);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        chk($sformatf("d%0d mem_en T+1", g), mem_en[g], 1);
        chk($sformatf("d%0d mem_addr T+1", g), mem_addr[g], a);
        chk($sformatf("d%0d mem_we T+1", g), mem_we[g], 0);
      end
      if (!if_valid[g] && g == 1) chk("d1 stall while pending", stall[g], 1);
    end while (!if_valid[g] && n < 12);
    chk($sformatf("d%0d fetch latency", g), n, exp_lat);
    chk($sformatf("d%0d fetch rdata", g), if_rdata[g], mem_fn(a));
    chk($sformatf("d%0d dmem_valid idle", g), dm_valid[g], 0);
    chk($sformatf("d%0d stall at valid", g), stall[g], 0);
    if_req[g] = 1'b0;
    tick();
    chk($sformatf("d%0d valid one cycle", g), if_valid[g], 0);
  endtask

  task automatic run_pairs(input bit gap, input string tag);
    int n;
    int fi;
    int di;
    fi = 0;
    di = 0;
    if_req[1]  = 1'b1;
    if_addr[1] = 10'h020;
    dm_req[1]  = 1'b1;
    dm_we[1]   = 1'b0;
    dm_addr[1] = 10'h040;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      do begin
        tick();
        n++;
        if (gap && n == 2) if_req[1] = 1'b1;
      end while (!if_valid[1] && !dm_valid[1] && n < 10);
      chk($sformatf("%s wait %0d", tag, k), n, (k == 0) ? 3 : 4);
      chk($sformatf("%s single valid %0d", tag, k), if_valid[1] & dm_valid[1], 0);
      chk($sformatf("%s order %0d", tag, k), dm_valid[1], k % 2);
      if (if_valid[1]) begin
        chk($sformatf("%s fetch data %0d", tag, k), if_rdata[1], mem_fn(10'(10'h020 + fi)));
        fi++;
        if_addr[1] = 10'(10'h020 + fi);
        if (gap) if_req[1] = 1'b0;
      end else begin
        chk($sformatf("%s load data %0d", tag, k), dm_rdata[1], mem_fn(10'(10'h040 + di)));
        di++;
        dm_addr[1] = 10'(10'h040 + di);
      end
    end
    if_req[1] = 1'b0;
    dm_req[1] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      if_req[g]   = 1'b0;
      if_addr[g]  = '0;
      dm_req[g]   = 1'b0;
      dm_we[g]    = 1'b0;
      dm_addr[g]  = '0;
      dm_wdata[g] = '0;
    end
    tick();
    tick();
    chk("reset mem_en", mem_en[1], 0);
    chk("reset mem_addr", mem_addr[1], 0);
    chk("reset if_rdata", if_rdata[1], 0);
    chk("reset valids", {if_valid[1], dm_valid[1]}, 0);
    chk("reset stall", stall[1], 0);
    rst = 1'b0;
    tick();

    fetch_once(1, 10'h004, 3);

    dm_req[1]   = 1'b1;
    dm_we[1]    = 1'b1;
    dm_addr[1]  = 10'h010;
    dm_wdata[1] = 32'hDEAD_BEEF;
    tick();
    chk("store mem_en", mem_en[1], 1);
    chk("store mem_we", mem_we[1], 1);
    chk("store mem_addr", mem_addr[1], 10'h010);
    chk("store mem_wdata", mem_wdata[1], 32'hDEAD_BEEF);
    tick();
    chk("store mem_en drop", mem_en[1], 0);
    chk("store mem_we drop", mem_we[1], 0);
    tick();
    chk("store ack", dm_valid[1], 1);
    chk("store no fetch valid", if_valid[1], 0);
    chk("store dmem_rdata kept", dm_rdata[1], 0);
    chk("store written addr", wr_addr, 10'h010);
    chk("store written data", wr_data, 32'hDEAD_BEEF);
    chk("store write count", wr_cnt, 1);
    dm_req[1] = 1'b0;
    dm_we[1]  = 1'b0;
    tick();
    chk("store ack one cycle", dm_valid[1], 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_pairs(1'b0, "tie");
    run_pairs(1'b1, "gap");

    if_req[1]  = 1'b1;
    if_addr[1] = 10'h004;
    tick();
    tick();
    chk("abort in WAIT", mem_en[1], 0);
    rst       = 1'b1;
    if_req[1] = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort mem_en", mem_en[1], 0);
    chk("abort mem_we", mem_we[1], 0);
    chk("abort mem_addr", mem_addr[1], 0);
    chk("abort valids", {if_valid[1], dm_valid[1]}, 0);
    chk("abort if_rdata", if_rdata[1], 0);
    chk("abort dm_rdata", dm_rdata[1], 0);
    chk("abort stall", stall[1], 0);
    tick();
    chk("abort no late valid", if_valid[1], 0);
    fetch_once(1, 10'h008, 3);

    fetch_once(0, 10'h004, 2);
    fetch_once(2, 10'h004, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
